// File: rtl/npc_pkg.sv
// npc_pkg: shared register-file defaults for the NPC core (index/data widths, register count, zero-register index)
package npc_pkg;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 64;
  localparam int RF_NREG = 2 ** RF_ADDR_WIDTH;
  localparam int RF_ZERO_IDX = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits; issue sets, write clears, flush wipes; ports clk/rst_n, wen/waddr, issue_valid/issue_rd/issue_ready, flush, busy_vec
module rf_scoreboard
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NWRITE = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NWRITE-1:0]            wen,
  input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
  input  logic                         issue_valid,
  input  logic [ADDR_WIDTH-1:0]        issue_rd,
  output logic                         issue_ready,
  input  logic                         flush,
  output logic [2**ADDR_WIDTH-1:0]     busy_vec
);
  localparam int NREG = 2 ** ADDR_WIDTH;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_d;
  logic rd_zero;
  assign rd_zero = ZERO_REG != 0 && issue_rd == ADDR_WIDTH'(RF_ZERO_IDX);
  assign issue_ready = !busy[issue_rd] || rd_zero;
  assign busy_vec = busy;
  // order encodes priority: write-clear < issue-set < flush
  always_comb begin
    busy_d = busy;
    for (int w = 0; w < NWRITE; w++)
      if (wen[w]) busy_d[waddr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    if (issue_valid && issue_ready && !rd_zero) busy_d[issue_rd] = 1'b1;
    if (flush) busy_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else busy <= busy_d;
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with NREAD comb reads, NWRITE prioritised writes, optional zero reg/bypass, plus issue scoreboard; ports clk/rst_n, raddr/rdata/rbusy, wen/waddr/wdata, issue_*, flush, busy_vec, array
module regfile_sb
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NREAD = 3,
  parameter int NWRITE = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NREAD*ADDR_WIDTH-1:0]          raddr,
  output logic [NREAD*DATA_WIDTH-1:0]          rdata,
  output logic [NREAD-1:0]                     rbusy,
  input  logic [NWRITE-1:0]                    wen,
  input  logic [NWRITE*ADDR_WIDTH-1:0]         waddr,
  input  logic [NWRITE*DATA_WIDTH-1:0]         wdata,
  input  logic                                 issue_valid,
  input  logic [ADDR_WIDTH-1:0]                issue_rd,
  output logic                                 issue_ready,
  input  logic                                 flush,
  output logic [2**ADDR_WIDTH-1:0]             busy_vec,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] array
);
  localparam int NREG = 2 ** ADDR_WIDTH;
  logic [NREG-1:0][DATA_WIDTH-1:0] regs;
  function automatic logic zr(input logic [ADDR_WIDTH-1:0] a);
    return ZERO_REG != 0 && a == ADDR_WIDTH'(RF_ZERO_IDX);
  endfunction
  assign array = regs;
  // later ports are assigned last so the highest-numbered port wins a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs <= '0;
    else
      for (int w = 0; w < NWRITE; w++)
        if (wen[w] && !zr(waddr[w*ADDR_WIDTH +: ADDR_WIDTH]))
          regs[waddr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[w*DATA_WIDTH +: DATA_WIDTH];
  end
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rdata[i*DATA_WIDTH +: DATA_WIDTH] = zr(raddr[i*ADDR_WIDTH +: ADDR_WIDTH]) ? '0 : regs[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      rbusy[i] = busy_vec[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      for (int w = 0; w < NWRITE; w++)
        if (BYPASS != 0 && wen[w] && !zr(raddr[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
            waddr[w*ADDR_WIDTH +: ADDR_WIDTH] == raddr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
          rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata[w*DATA_WIDTH +: DATA_WIDTH];
          rbusy[i] = 1'b0;
        end
    end
  end
  rf_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NWRITE(NWRITE),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .wen(wen),
    .waddr(waddr),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .flush(flush),
    .busy_vec(busy_vec)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed table, corner sequences and randomized model check of regfile_sb
module tb_regfile_sb;
  logic clk = 0;
  logic rst_n = 0;
  logic [14:0] raddr = '0;
  logic [191:0] rdata, rdata1;
  logic [2:0] rbusy, rbusy1;
  logic [1:0] wen = '0;
  logic [9:0] waddr = '0;
  logic [127:0] wdata = '0;
  logic issue_valid = 0;
  logic [4:0] issue_rd = '0;
  logic issue_ready, issue_ready1;
  logic flush = 0;
  logic [31:0] busy_vec, busy_vec1;
  logic [2047:0] arr, arr1;
  int checks = 0;
  int errors = 0;
  logic [63:0] mem [32];
  logic [31:0] mbusy;
  always #5 clk = ~clk;
  regfile_sb u0 (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_ready(issue_ready), .flush(flush),
    .busy_vec(busy_vec), .array(arr)
  );
  regfile_sb #(.BYPASS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata1), .rbusy(rbusy1),
    .wen(wen), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_ready(issue_ready1), .flush(flush),
    .busy_vec(busy_vec1), .array(arr1)
  );
  typedef struct {
    logic [1:0] wen;
    logic [4:0] wa0, wa1;
    logic [63:0] wd0, wd1;
    logic iv;
    logic [4:0] ird;
    logic fl;
    logic [4:0] ra0;
    logic [63:0] e_rd;
    logic e_rb;
    logic e_rdy;
    logic [31:0] e_bv;
  } row_t;
  row_t rows [15];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] m_rd(input logic [4:0] a);
    logic [63:0] v;
    if (a == 0) return '0;
    v = mem[a];
    for (int w = 0; w < 2; w++) if (wen[w] && waddr[w*5 +: 5] == a) v = wdata[w*64 +: 64];
    return v;
  endfunction
  function automatic logic m_rb(input logic [4:0] a);
    for (int w = 0; w < 2; w++) if (wen[w] && waddr[w*5 +: 5] == a && a != 0) return 1'b0;
    return mbusy[a];
  endfunction
  function automatic logic m_rdy();
    return !mbusy[issue_rd] || issue_rd == 0;
  endfunction
  task automatic m_clear();
    for (int r = 0; r < 32; r++) mem[r] = '0;
    mbusy = '0;
  endtask
  task automatic step();
    logic rdy;
    @(posedge clk);
    rdy = m_rdy();
    for (int w = 0; w < 2; w++) if (wen[w] && waddr[w*5 +: 5] != 0) mem[waddr[w*5 +: 5]] = wdata[w*64 +: 64];
    if (flush) mbusy = '0;
    else begin
      for (int w = 0; w < 2; w++) if (wen[w]) mbusy[waddr[w*5 +: 5]] = 1'b0;
      if (issue_valid && rdy && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask
  task automatic idle();
    wen = '0; issue_valid = 0; flush = 0;
  endtask
  initial begin
    m_clear();
    rows[0]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 32'h0};
    rows[1]  = '{2'b01, 5'd5, 5'd0, 64'h1234, 64'h0, 1'b0, 5'd0, 1'b0, 5'd5, 64'h1234, 1'b0, 1'b1, 32'h0};
    rows[2]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 1'b0, 5'd5, 64'h1234, 1'b0, 1'b1, 32'h0};
    rows[3]  = '{2'b11, 5'd7, 5'd7, 64'hAA, 64'hBB, 1'b0, 5'd0, 1'b0, 5'd7, 64'hBB, 1'b0, 1'b1, 32'h0};
    rows[4]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 1'b0, 5'd7, 64'hBB, 1'b0, 1'b1, 32'h0};
    rows[5]  = '{2'b01, 5'd0, 5'd0, 64'hFF, 64'h0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 32'h0};
    rows[6]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 32'h0};
    rows[7]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 5'd3, 1'b0, 5'd3, 64'h0, 1'b0, 1'b1, 32'h0};
    rows[8]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 5'd3, 1'b0, 5'd3, 64'h0, 1'b1, 1'b0, 32'h8};
    rows[9]  = '{2'b01, 5'd3, 5'd0, 64'h33, 64'h0, 1'b0, 5'd3, 1'b0, 5'd3, 64'h33, 1'b0, 1'b0, 32'h8};
    rows[10] = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd3, 1'b0, 5'd3, 64'h33, 1'b0, 1'b1, 32'h0};
    rows[11] = '{2'b01, 5'd4, 5'd0, 64'h44, 64'h0, 1'b1, 5'd4, 1'b0, 5'd4, 64'h44, 1'b0, 1'b1, 32'h0};
    rows[12] = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd4, 1'b0, 5'd4, 64'h44, 1'b1, 1'b0, 32'h10};
    rows[13] = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 5'd6, 1'b1, 5'd6, 64'h0, 1'b0, 1'b1, 32'h10};
    rows[14] = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd6, 1'b0, 5'd6, 64'h0, 1'b0, 1'b1, 32'h0};
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 15; i++) begin
      wen = rows[i].wen;
      waddr = {rows[i].wa1, rows[i].wa0};
      wdata = {rows[i].wd1, rows[i].wd0};
      issue_valid = rows[i].iv;
      issue_rd = rows[i].ird;
      flush = rows[i].fl;
      raddr = {5'd31, 5'd5, rows[i].ra0};
      #1;
      chk($sformatf("row%0d rdata0", i), rdata[63:0], rows[i].e_rd);
      chk($sformatf("row%0d rbusy0", i), {63'h0, rbusy[0]}, {63'h0, rows[i].e_rb});
      chk($sformatf("row%0d issue_ready", i), {63'h0, issue_ready}, {63'h0, rows[i].e_rdy});
      chk($sformatf("row%0d busy_vec", i), {32'h0, busy_vec}, {32'h0, rows[i].e_bv});
      if (i == 0) begin
        chk("reset rdata1", rdata[127:64], 64'h0);
        chk("reset rdata2", rdata[191:128], 64'h0);
        chk("reset rbusy", {61'h0, rbusy}, 64'h0);
      end
      if (i == 1) chk("nobypass rdata0", rdata1[63:0], 64'h0);
      if (i == 2) chk("nobypass rdata0 next", rdata1[63:0], 64'h1234);
      step();
    end
    idle();
    issue_rd = 5'd10; issue_valid = 1;
    wen = 2'b10; waddr = {5'd11, 5'd0}; wdata = {64'h5A5A, 64'h0};
    step();
    idle();
    raddr = {5'd0, 5'd0, 5'd11};
    #1;
    chk("pre-reset reg11", rdata[63:0], 64'h5A5A);
    chk("pre-reset busy10", {32'h0, busy_vec}, 64'h400);
    #1 rst_n = 0;
    #1;
    chk("async reset array", {63'h0, |arr}, 64'h0);
    chk("async reset busy_vec", {32'h0, busy_vec}, 64'h0);
    chk("async reset rdata", rdata[63:0], 64'h0);
    chk("async reset ready", {63'h0, issue_ready}, 64'h1);
    m_clear();
    @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 400; n++) begin
      logic [4:0] pr;
      wen = 2'($urandom);
      waddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wdata = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      issue_valid = 1'($urandom);
      issue_rd = 5'($urandom_range(0, 7));
      flush = $urandom_range(0, 19) == 0;
      raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      pr = 5'($urandom_range(0, 7));
      #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rand%0d rdata%0d", n, i), rdata[i*64 +: 64], m_rd(raddr[i*5 +: 5]));
        chk($sformatf("rand%0d rbusy%0d", n, i), {63'h0, rbusy[i]}, {63'h0, m_rb(raddr[i*5 +: 5])});
      end
      chk($sformatf("rand%0d issue_ready", n), {63'h0, issue_ready}, {63'h0, m_rdy()});
      chk($sformatf("rand%0d busy_vec", n), {32'h0, busy_vec}, {32'h0, mbusy});
      chk($sformatf("rand%0d array", n), arr[pr*64 +: 64], mem[pr]);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
